// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor: one shared 4-bit slice, LSB nibble first,
// carry registered between nibbles, valid/ready handshakes on both sides.

module adder_4b_ins (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
endmodule

module nibble_serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic             last_step;

  adder_4b_ins u_slice (
    .x    (a_nib),
    .y    (b_nib),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Select the operand nibbles feeding the shared slice this step.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end else begin
        a_nib = a_nib;
        b_nib = b_nib;
      end
    end
  end

  assign last_step = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and request-side ready.
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    case (state)
      IDLE: begin
        start_ready = ~rst;
        if (start_valid) next_state = RUN;
        else             next_state = IDLE;
      end
      RUN: begin
        if (last_step) next_state = DONE;
        else           next_state = RUN;
      end
      DONE: begin
        if (done_ready) next_state = IDLE;
        else            next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      result     <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;  // subtraction is A + ~B + 1
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) result[4*i +: 4] <= slice_sum;
          end
          carry <= slice_cout;
          idx   <= idx + IW'(1);
          if (last_step) begin
            cout       <= slice_cout;
            ovf        <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (slice_sum[3] != a_reg[WIDTH-1]);
            done_valid <= 1'b1;
          end
        end
        DONE: begin
          if (done_ready) done_valid <= 1'b0;
        end
        default: begin
          done_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
